// File: rtl/bpf_mem_pkg.sv
// Shared definitions for the eBPF data-memory load/store paths: size codes,
// sequencer states and size-derived masks.
package bpf_mem_pkg;

  typedef enum logic [1:0] {
    SZ_W  = 2'b00,
    SZ_H  = 2'b01,
    SZ_B  = 2'b10,
    SZ_DW = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT,
    ST_WR,
    ST_DONE
  } state_e;

  function automatic logic [63:0] size_mask(size_e sz);
    case (sz)
      SZ_B:    return 64'h0000_0000_0000_00FF;
      SZ_H:    return 64'h0000_0000_0000_FFFF;
      SZ_W:    return 64'h0000_0000_FFFF_FFFF;
      default: return '1;
    endcase
  endfunction

  function automatic logic misaligned(size_e sz, logic [2:0] lane);
    case (sz)
      SZ_H:    return lane[0] != 1'b0;
      SZ_W:    return lane[1:0] != 2'b00;
      SZ_DW:   return lane != 3'b000;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/store_merge.sv
// Little-endian lane merge of store data into an existing 64-bit RAM word.
module store_merge
  import bpf_mem_pkg::*;
(
  input  logic [63:0] old_i,
  input  logic [63:0] data_i,
  input  size_e       size_i,
  input  logic [2:0]  lane_i,
  output logic [63:0] wdata_o
);

  logic [5:0]  sh;
  logic [63:0] smask;
  logic [63:0] lmask;

  always_comb begin
    sh      = {lane_i, 3'b000};
    smask   = size_mask(size_i);
    lmask   = smask << sh;
    wdata_o = (old_i & ~lmask) | ((data_i & smask) << sh);
  end

endmodule

// File: rtl/mem_store_unit.sv
// eBPF ST/STX store sequencer: computes the effective address, rejects bad
// addresses, and writes B/H/W via read-modify-write or DW directly.
module mem_store_unit
  import bpf_mem_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        size,
  input  logic [63:0]       base,
  input  logic [15:0]       offset,
  input  logic [63:0]       data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-4:0] ram_addr,
  output logic              ram_rd,
  input  logic [63:0]       ram_rdata,
  output logic              ram_wr,
  output logic [63:0]       ram_wdata
);

  localparam int CW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

  state_e            state_q;
  size_e             size_in;
  size_e             size_q;
  logic [2:0]        lane_q;
  logic [63:0]       data_q;
  logic [CW-1:0]     cnt_q;
  logic              busy_q, done_q, err_q, rd_q, wr_q;
  logic [ADDR_W-4:0] addr_q;
  logic [63:0]       wdata_q;
  logic [63:0]       wdata_d;
  logic [63:0]       ea;
  logic              ea_err;

  // The address check is evaluated on the accept edge, so the CHK decision
  // lands in cycle 0 and the first strobe (or done/err) appears in cycle 1.
  always_comb begin
    size_in = size_e'(size);
    ea      = base + {{48{offset[15]}}, offset};
    ea_err  = ((ea >> ADDR_W) != '0) || misaligned(size_in, ea[2:0]);
  end

  store_merge u_merge (
    .old_i   (ram_rdata),
    .data_i  (data_q),
    .size_i  (size_q),
    .lane_i  (lane_q),
    .wdata_o (wdata_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      size_q  <= SZ_W;
      lane_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            size_q <= size_in;
            lane_q <= ea[2:0];
            data_q <= data;
            busy_q <= 1'b1;
            if (ea_err) begin
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              state_q <= ST_DONE;
            end else if (size_in == SZ_DW) begin
              addr_q  <= ea[ADDR_W-1:3];
              wdata_q <= data;
              wr_q    <= 1'b1;
              state_q <= ST_WR;
            end else begin
              addr_q  <= ea[ADDR_W-1:3];
              rd_q    <= 1'b1;
              state_q <= ST_RD;
            end
          end
        end
        ST_RD: begin
          rd_q    <= 1'b0;
          cnt_q   <= CW'(RAM_LAT - 1);
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            wdata_q <= wdata_d;
            wr_q    <= 1'b1;
            state_q <= ST_WR;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_WR: begin
          wr_q    <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign ram_rd    = rd_q;
  assign ram_wr    = wr_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_mem_store_unit.sv
// Bench for mem_store_unit: RAM_LAT=1 and RAM_LAT=3 instances run side by side
// against hand-computed vectors, overlap/reset sequences and a byte-array model.
module tb_mem_store_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  size = '0;
  logic [63:0] base = '0;
  logic [15:0] offset = '0;
  logic [63:0] data = '0;

  logic [1:0]        busy_v, done_v, err_v, rd_v, wr_v;
  logic [1:0][12:0]  addr_v;
  logic [1:0][63:0]  wdata_v, rdata_v;

  logic        pre_en = 1'b0;
  logic [12:0] pre_addr = '0;
  logic [63:0] pre_val = '0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [63:0] mem [8192];
    logic [63:0] pipe [3];

    mem_store_unit #(.ADDR_W(16), .RAM_LAT(LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .size      (size),
      .base      (base),
      .offset    (offset),
      .data      (data),
      .busy      (busy_v[g]),
      .done      (done_v[g]),
      .err       (err_v[g]),
      .ram_addr  (addr_v[g]),
      .ram_rd    (rd_v[g]),
      .ram_rdata (rdata_v[g]),
      .ram_wr    (wr_v[g]),
      .ram_wdata (wdata_v[g])
    );

    // Read data is garbage unless a read was issued, so mistimed capture shows up.
    always @(posedge clk) begin
      if (pre_en) mem[pre_addr] <= pre_val;
      else if (wr_v[g]) mem[addr_v[g]] <= wdata_v[g];
      pipe[0] <= rd_v[g] ? mem[addr_v[g]] : {$urandom, $urandom};
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign rdata_v[g] = pipe[LAT-1];
  end

  typedef struct {
    logic [1:0]  size;
    logic [63:0] base;
    logic [15:0] off;
    logic [63:0] data;
    logic [63:0] old;
    logic        exp_err;
    logic [12:0] exp_addr;
    logic [63:0] exp_wdata;
  } vec_t;

  int nerr = 0;
  int nchk = 0;

  int rd_cyc[2], wr_cyc[2], done_cyc[2], nrd[2], nwr[2], nbusy[2], busy_last[2];
  int both_bad[2], err_stray[2];
  logic errd[2];
  logic [12:0] rd_addr[2], wr_addr[2];
  logic [63:0] wr_data[2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(logic [1:0] sz, logic [63:0] b, logic [15:0] o, logic [63:0] d,
                               logic [63:0] old, logic e, logic [12:0] a, logic [63:0] w);
    vec_t v;
    v.size = sz; v.base = b; v.off = o; v.data = d; v.old = old;
    v.exp_err = e; v.exp_addr = a; v.exp_wdata = w;
    return v;
  endfunction

  // Reference: byte-by-byte placement into the old word.
  function automatic vec_t mk_model(logic [1:0] sz, logic [63:0] b, logic [15:0] o,
                                    logic [63:0] d, logic [63:0] old);
    vec_t v;
    logic [63:0] ea;
    int nb, lane;
    ea = b + {{48{o[15]}}, o};
    nb = (sz == 2'b10) ? 1 : (sz == 2'b01) ? 2 : (sz == 2'b00) ? 4 : 8;
    lane = int'(ea[2:0]);
    v.size = sz; v.base = b; v.off = o; v.data = d; v.old = old;
    v.exp_err = (ea[63:16] != 48'd0) || ((lane % nb) != 0);
    v.exp_addr = ea[15:3];
    v.exp_wdata = old;
    if (!v.exp_err)
      for (int i = 0; i < nb; i++) v.exp_wdata[(lane + i) * 8 +: 8] = d[i * 8 +: 8];
    return v;
  endfunction

  task automatic run_op(input vec_t v, input int s2, input int rc);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = v.exp_addr; pre_val = v.old;
    @(negedge clk);
    pre_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rd_cyc[k] = 0; wr_cyc[k] = 0; done_cyc[k] = 0; nrd[k] = 0; nwr[k] = 0;
      nbusy[k] = 0; busy_last[k] = 0; both_bad[k] = 0; err_stray[k] = 0; errd[k] = 1'b0;
      rd_addr[k] = '0; wr_addr[k] = '0; wr_data[k] = '0;
    end
    size = v.size; base = v.base; offset = v.off; data = v.data; start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rd_v[k]) begin
          nrd[k]++;
          if (rd_cyc[k] == 0) begin rd_cyc[k] = c; rd_addr[k] = addr_v[k]; end
        end
        if (wr_v[k]) begin
          nwr[k]++;
          if (wr_cyc[k] == 0) begin wr_cyc[k] = c; wr_addr[k] = addr_v[k]; wr_data[k] = wdata_v[k]; end
        end
        if (done_v[k] && done_cyc[k] == 0) begin done_cyc[k] = c; errd[k] = err_v[k]; end
        if (err_v[k] && !done_v[k]) err_stray[k]++;
        if (rd_v[k] && wr_v[k]) both_bad[k]++;
        if (busy_v[k]) begin nbusy[k]++; busy_last[k] = c; end
      end
      start = 1'b0;
      if (c == s2) begin
        start = 1'b1; size = 2'b11; base = 64'h300; offset = '0; data = 64'hBADBADBADBADBAD0;
      end
      rst = (c == rc);
    end
    start = 1'b0;
    rst = 1'b0;
  endtask

  task automatic check_op(input vec_t v, input int rc, input string tag);
    for (int k = 0; k < 2; k++) begin
      int lat, e_rd, e_wr, e_done, e_busy;
      logic e_err;
      string p;
      lat = (k == 0) ? 1 : 3;
      if (rc != 0) begin
        e_rd = 1; e_wr = 0; e_done = 0; e_busy = rc; e_err = 1'b0;
      end else if (v.exp_err) begin
        e_rd = 0; e_wr = 0; e_done = 1; e_busy = 1; e_err = 1'b1;
      end else if (v.size == 2'b11) begin
        e_rd = 0; e_wr = 1; e_done = 2; e_busy = 2; e_err = 1'b0;
      end else begin
        e_rd = 1; e_wr = 2 + lat; e_done = 3 + lat; e_busy = 3 + lat; e_err = 1'b0;
      end
      p = $sformatf("%s/lat%0d", tag, lat);
      chk({p, "/done_cyc"}, 64'(done_cyc[k]), 64'(e_done));
      chk({p, "/err"}, 64'(errd[k]), 64'(e_err));
      chk({p, "/rd_cyc"}, 64'(rd_cyc[k]), 64'(e_rd));
      chk({p, "/wr_cyc"}, 64'(wr_cyc[k]), 64'(e_wr));
      chk({p, "/n_rd"}, 64'(nrd[k]), 64'((e_rd != 0) ? 1 : 0));
      chk({p, "/n_wr"}, 64'(nwr[k]), 64'((e_wr != 0) ? 1 : 0));
      chk({p, "/busy_cycles"}, 64'(nbusy[k]), 64'(e_busy));
      chk({p, "/busy_last"}, 64'(busy_last[k]), 64'(e_busy));
      chk({p, "/rd_wr_overlap"}, 64'(both_bad[k]), 64'd0);
      chk({p, "/err_without_done"}, 64'(err_stray[k]), 64'd0);
      if (e_rd != 0) chk({p, "/rd_addr"}, 64'(rd_addr[k]), 64'(v.exp_addr));
      if (e_wr != 0) begin
        chk({p, "/wr_addr"}, 64'(wr_addr[k]), 64'(v.exp_addr));
        chk({p, "/wr_data"}, wr_data[k], v.exp_wdata);
      end
    end
  endtask

  vec_t tbl[14];
  vec_t rv;

  initial begin
    tbl[0]  = mkv(2'b11, 64'h100,   16'h0008, 64'h1122334455667788, 64'hA5A5A5A5A5A5A5A5, 1'b0, 13'h21,   64'h1122334455667788);
    tbl[1]  = mkv(2'b10, 64'h203,   16'h0000, 64'h55555555555555AB, 64'hFFFFFFFFFFFFFFFF, 1'b0, 13'h40,   64'hFFFFFFFFABFFFFFF);
    tbl[2]  = mkv(2'b01, 64'h10A,   16'hFFFC, 64'h00000000DEADBEEF, 64'h0000000000000000, 1'b0, 13'h20,   64'hBEEF000000000000);
    tbl[3]  = mkv(2'b00, 64'h102,   16'h0000, 64'h0000000012345678, 64'h0,                1'b1, 13'h0,    64'h0);
    tbl[4]  = mkv(2'b11, 64'h10000, 16'h0000, 64'h1111111111111111, 64'h0,                1'b1, 13'h0,    64'h0);
    tbl[5]  = mkv(2'b00, 64'h1000,  16'h0004, 64'hCAFEF00D12345678, 64'h0123456789ABCDEF, 1'b0, 13'h200,  64'h1234567889ABCDEF);
    tbl[6]  = mkv(2'b01, 64'h7FF8,  16'h0000, 64'h000000001234AAAA, 64'hFFFFFFFFFFFFFFFF, 1'b0, 13'hFFF,  64'hFFFFFFFFFFFFAAAA);
    tbl[7]  = mkv(2'b10, 64'hFFFF,  16'h0000, 64'h000000000000005A, 64'h0,                1'b0, 13'h1FFF, 64'h5A00000000000000);
    tbl[8]  = mkv(2'b11, 64'h10,    16'hFFF0, 64'h0F1E2D3C4B5A6978, 64'hFFFFFFFFFFFFFFFF, 1'b0, 13'h0,    64'h0F1E2D3C4B5A6978);
    tbl[9]  = mkv(2'b11, 64'h0,     16'hFFF8, 64'h2222222222222222, 64'h0,                1'b1, 13'h0,    64'h0);
    tbl[10] = mkv(2'b01, 64'h201,   16'h0000, 64'h3333333333333333, 64'h0,                1'b1, 13'h0,    64'h0);
    tbl[11] = mkv(2'b10, 64'hFFFF,  16'h0001, 64'h4444444444444444, 64'h0,                1'b1, 13'h0,    64'h0);
    tbl[12] = mkv(2'b11, 64'h104,   16'h0000, 64'h5555555555555555, 64'h0,                1'b1, 13'h0,    64'h0);
    tbl[13] = mkv(2'b00, 64'hFFFC,  16'h0000, 64'h89ABCDEF00C0FFEE, 64'h1111111122222222, 1'b0, 13'h1FFF, 64'h00C0FFEE22222222);

    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset/%0d/ctrl", k), 64'({busy_v[k], done_v[k], err_v[k], rd_v[k], wr_v[k]}), 64'd0);
      chk($sformatf("reset/%0d/addr", k), 64'(addr_v[k]), 64'd0);
      chk($sformatf("reset/%0d/wdata", k), wdata_v[k], 64'd0);
    end
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      run_op(tbl[i], 0, 0);
      check_op(tbl[i], 0, $sformatf("vec%0d", i));
    end

    run_op(tbl[1], 2, 0);
    check_op(tbl[1], 0, "start_while_busy");
    run_op(tbl[1], 4, 0);
    check_op(tbl[1], 0, "start_in_done");
    run_op(tbl[1], 0, 2);
    check_op(tbl[1], 2, "rst_in_wait");
    run_op(tbl[2], 0, 0);
    check_op(tbl[2], 0, "after_rst");

    for (int i = 0; i < 24; i++) begin
      logic [63:0] b;
      logic [15:0] o;
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) b = {$urandom, $urandom};
      else b = 64'($urandom_range(0, 65535));
      o = 16'($urandom_range(0, 65535));
      if (r < 6) begin b[2:0] = 3'b000; o[2:0] = 3'b000; end
      rv = mk_model(2'($urandom_range(0, 3)), b, o, {$urandom, $urandom}, {$urandom, $urandom});
      run_op(rv, 0, 0);
      check_op(rv, 0, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
